// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the synchronous FIFO
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: WIDTH x DEPTH storage, one write port, one registered read port with write-through
module sync_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             bypass,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clock)
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= bypass ? wr_data : mem[rd_addr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with count, threshold flags and sticky errors
module sync_fifo_param import sync_fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [WIDTH-1:0]      fifo_in,
  output logic [WIDTH-1:0]      fifo_out,
  output logic                  fifo_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [clog2(DEPTH):0] fifo_count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_N = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_N = (AW+1)'(AE_LEVEL);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          bypass, do_rd, wr_acc;
  assign fifo_empty = fifo_count == '0;
  assign fifo_full = fifo_count == FULL_N;
  assign almost_empty = fifo_count <= AE_N;
  assign almost_full = fifo_count >= AF_N;
  assign bypass = write && read && fifo_empty;
  assign do_rd = read && !fifo_empty;
  assign wr_acc = write && (!fifo_full || read) && !bypass;
  always_ff @(posedge clock)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      fifo_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(do_rd);
      fifo_count <= fifo_count + (AW+1)'(wr_acc) - (AW+1)'(do_rd);
      fifo_valid <= do_rd || bypass;
      overflow <= overflow || (write && fifo_full && !read);
      underflow <= underflow || (read && fifo_empty && !write);
    end
  sync_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_acc && !reset),
    .wr_addr (wr_ptr),
    .wr_data (fifo_in),
    .rd_en   (do_rd || bypass),
    .bypass  (bypass),
    .rd_addr (rd_ptr),
    .rd_data (fifo_out)
  );
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed checks of sync_fifo_param against a queue model
module tb_sync_fifo_param;
  localparam int D = 16;
  logic        clock, reset, write, read;
  logic [15:0] fifo_in, fifo_out;
  logic        fifo_valid, fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow;
  logic [4:0]  fifo_count;
  int          n_tests, n_fail;
  logic [15:0] q[$];
  logic [15:0] m_out;
  logic        m_valid, m_ov, m_un;

  sync_fifo_param dut (
    .clock(clock), .reset(reset), .write(write), .read(read), .fifo_in(fifo_in),
    .fifo_out(fifo_out), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic rs, input logic w, input logic r, input logic [15:0] d);
    int sz;
    sz = q.size();
    if (rs) begin
      q.delete();
      m_out = '0;
      m_valid = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (w && r && sz == 0) begin
        m_out = d;
        m_valid = 1'b1;
      end else begin
        if (r && sz > 0) begin
          m_out = q.pop_front();
          m_valid = 1'b1;
        end
        if (w && (sz < D || r)) q.push_back(d);
      end
      if (w && !r && sz == D) m_ov = 1'b1;
      if (r && !w && sz == 0) m_un = 1'b1;
    end
  endtask

  task automatic step(input logic rs, input logic w, input logic r, input logic [15:0] d);
    int sz;
    reset = rs;
    write = w;
    read = r;
    fifo_in = d;
    model(rs, w, r, d);
    @(posedge clock);
    #1;
    sz = q.size();
    check("fifo_out", 32'(fifo_out), 32'(m_out));
    check("fifo_valid", 32'(fifo_valid), 32'(m_valid));
    check("fifo_count", 32'(fifo_count), sz);
    check("fifo_empty", 32'(fifo_empty), 32'(sz == 0));
    check("fifo_full", 32'(fifo_full), 32'(sz == D));
    check("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    check("almost_full", 32'(almost_full), 32'(sz >= D - 2));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
  endtask

  initial begin
    logic [15:0] v;
    int wp;
    n_tests = 0;
    n_fail = 0;
    m_out = '0;
    m_valid = 1'b0;
    m_ov = 1'b0;
    m_un = 1'b0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 16'h5555);
    check("reset_count", 32'(fifo_count), 0);
    for (int i = 1; i <= D; i++) step(0, 1, 0, 16'(i));
    check("full_after_16", 32'(fifo_full), 1);
    step(0, 1, 0, 16'hBEEF);
    check("overflow_set", 32'(overflow), 1);
    step(0, 1, 1, 16'h0077);
    check("full_rw_count", 32'(fifo_count), D);
    check("full_rw_out", 32'(fifo_out), 1);
    for (int i = 2; i <= D; i++) begin
      step(0, 0, 1, 0);
      check("ordered_out", 32'(fifo_out), i);
    end
    step(0, 0, 1, 0);
    check("drained_out", 32'(fifo_out), 16'h0077);
    step(0, 0, 1, 0);
    check("underflow_set", 32'(underflow), 1);
    check("underflow_hold", 32'(fifo_out), 16'h0077);
    step(0, 1, 1, 16'h1234);
    check("bypass_out", 32'(fifo_out), 16'h1234);
    check("bypass_count", 32'(fifo_count), 0);
    step(1, 0, 0, 0);
    v = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, v);
      v++;
    end
    wp = 16'h0100;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, v);
      v++;
      check("stream_out", 32'(fifo_out), wp);
      wp++;
    end
    check("stream_count", 32'(fifo_count), 10);
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 16'(16'hA0 + i));
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 1, 1, 16'hCAFE);
    check("rst_mid_count", 32'(fifo_count), 0);
    check("rst_mid_empty", 32'(fifo_empty), 1);
    check("rst_mid_out", 32'(fifo_out), 0);
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < bias,
           $urandom_range(0, 99) >= bias, 16'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 16: number of storage entries, SHALL be a power of two, >= 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold, 1 <= AF_LEVEL < DEPTH.
REQ-004 Parameter AE_LEVEL, default 2: almost-empty threshold, 1 <= AE_LEVEL < DEPTH.
REQ-005 Port clock  input  1  rising-edge clock; all state SHALL change only on its rising edge.
REQ-006 Port reset  input  1  reset, synchronous, active-high.
REQ-007 Port write  input  1  write request; fifo_in is sampled on the same edge.
REQ-008 Port read  input  1  read request.
REQ-009 Port fifo_in  input  WIDTH  write data.
REQ-010 Port fifo_out  output  WIDTH  registered read data.
REQ-011 Port fifo_valid  output  1  pulses high for one cycle when fifo_out has been updated by an accepted read.
REQ-012 Port fifo_empty  output  1  high when count == 0.
REQ-013 Port fifo_full  output  1  high when count == DEPTH.
REQ-014 Port almost_empty  output  1  high when count <= AE_LEVEL.
REQ-015 Port almost_full  output  1  high when count >= AF_LEVEL.
REQ-016 Port fifo_count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH inclusive.
REQ-017 Port overflow  output  1  sticky; set by a rejected write.
REQ-018 Port underflow  output  1  sticky; set by a rejected read.

Function
REQ-019 Accepted write: write && (!fifo_full || read); stores fifo_in at wr_ptr and advances wr_ptr modulo DEPTH.
REQ-020 Accepted read: read && !fifo_empty; loads fifo_out from rd_ptr on the next edge (latency 1), asserts fifo_valid, and advances rd_ptr modulo DEPTH.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; no comparison against a literal.
REQ-022 fifo_count SHALL change by +1 on write-only, -1 on read-only, and stay unchanged on simultaneous accepted read and write.
REQ-023 Read and write on a full FIFO: both accepted, count stays DEPTH, and overflow is not set.
REQ-024 Read and write on an empty FIFO: fifo_out <= fifo_in on the next edge, fifo_valid = 1, count stays 0, pointers unchanged, and underflow is not set (bypass).
REQ-025 Write on full without read: data dropped, state unchanged, overflow <= 1.
REQ-026 Read on empty without write: fifo_out held, fifo_valid = 0, underflow <= 1.
REQ-027 Status flags SHALL be combinational decodes of the registered count, so they are valid in the cycle after the causing edge.
REQ-028 fifo_out SHALL hold its value on every cycle without an accepted read or bypass.

Reset
REQ-029 While reset is high: rd_ptr = wr_ptr = 0, count = 0, fifo_out = 0, fifo_valid = 0, overflow = underflow = 0.
REQ-030 Reset SHALL take priority over read and write in the same cycle; any in-flight data is discarded.
REQ-031 Storage array contents are not reset; no output SHALL expose them before they are written.

Structure
REQ-032 Shared package sync_fifo_pkg SHALL hold the clog2 function and the default WIDTH/DEPTH constants.
REQ-033 Storage SHALL be a separate sub-module sync_fifo_ram (one write port, one registered read port, WIDTH x DEPTH); control and flags stay in sync_fifo_param.

Verification
REQ-034 Reset, write 0x0001..0x0010 (DEPTH=16), then read 16 -> fifo_out 0x0001..0x0010 in order, each one cycle after read; fifo_full high after the 16th write; count 16 -> 0.
REQ-035 Full, then write 0xBEEF -> overflow = 1, count 16, 0xBEEF never read out.
REQ-036 Empty, read -> underflow = 1, fifo_valid = 0, fifo_out unchanged; empty with read+write of 0x1234 -> fifo_out = 0x1234 next cycle, count 0.
REQ-037 Fill 10, then 40 cycles of read+write with an incrementing pattern -> count stays 10, pointers wrap, and data order is preserved.
REQ-038 Count sweep 0..16..0 -> almost_empty high for count <= 2, almost_full high for count >= 14, exactly.
REQ-039 Reset asserted at count 7 during a read+write -> next cycle count 0, empty = 1, sticky flags cleared, fifo_out = 0.
